// File: rtl/led_sched_pkg.sv
// Shared state encoding, configuration payload, timing defaults and log2 helper
// for the LED phase scheduler.
package led_sched_pkg;

  localparam int unsigned PHASE_CYCLES_DEF  = 12;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned ADC_W_DEF         = 8;
  localparam int unsigned PGA_W             = 4;
  localparam int unsigned DC_W              = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RED  = 2'd1,
    ST_IR   = 2'd2,
    ST_DARK = 2'd3
  } sched_state_e;

  // Per-frame LED settings, captured at frame start
  typedef struct packed {
    logic [PGA_W-1:0] red_pga;
    logic [DC_W-1:0]  red_dc;
    logic [PGA_W-1:0] ir_pga;
    logic [DC_W-1:0]  ir_dc;
  } led_cfg_t;

  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_window_avg.sv
// Windowed ADC accumulator shared by all phases; avg is the rounded-down mean
// including the sample presented on the clearing cycle.
module adc_window_avg
  import led_sched_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned N     = PHASE_CYCLES_DEF - SETTLE_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [ADC_W-1:0] ADC,
  output logic [ADC_W-1:0] avg
);

  localparam int unsigned SHIFT = log2_ceil(N);
  localparam int unsigned ACC_W = ADC_W + SHIFT;

  logic [ACC_W-1:0] acc_q, acc_d, sum_c;

  always_comb begin
    sum_c = acc_q;
    if (acc_en) sum_c = acc_q + ACC_W'(ADC);
    acc_d = clr ? '0 : sum_c;
  end

  assign avg = ADC_W'(sum_c >> SHIFT);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/led_phase_scheduler.sv
// Time-multiplexed RED -> IR (-> DARK) LED scheduler with per-phase ADC averaging.
// Define LED_SCHED_DARK_PHASE_EN for the ambient DARK phase and corrected outputs.
module led_phase_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES  = PHASE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned ADC_W         = ADC_W_DEF
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PGA_W-1:0] RED_PGA,
  input  logic [DC_W-1:0]  RED_DC_Comp,
  input  logic [PGA_W-1:0] IR_PGA,
  input  logic [DC_W-1:0]  IR_DC_Comp,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
`ifdef LED_SCHED_DARK_PHASE_EN
  output logic [ADC_W-1:0] DARK_ADC_Value,
`endif
  output logic             sample_valid,
  output logic             busy
);

  localparam int unsigned N          = PHASE_CYCLES - SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (log2_ceil(PHASE_CYCLES) > 0) ? log2_ceil(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  led_cfg_t         cfg_q, cfg_d;
  logic [ADC_W-1:0] red_res_q, red_res_d;
  logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [PGA_W-1:0] pga_q, pga_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [ADC_W-1:0] red_val_q, red_val_d, ir_val_q, ir_val_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic             last_c, acc_en_c, clr_c, frame_end_c, start_c;
  logic [ADC_W-1:0] avg_c;

`ifdef LED_SCHED_DARK_PHASE_EN
  logic [ADC_W-1:0] ir_res_q, ir_res_d, dark_val_q, dark_val_d;

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction
`endif

  adc_window_avg #(
    .ADC_W (ADC_W),
    .N     (N)
  ) u_avg (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .acc_en (acc_en_c),
    .ADC    (ADC),
    .avg    (avg_c)
  );

  // Next state, phase results and frame outputs
  always_comb begin
    last_c      = (cnt_q == CNT_LAST);
    acc_en_c    = (state_q != ST_IDLE) && (cnt_q >= CNT_SETTLE);
    clr_c       = (state_q != ST_IDLE) && last_c;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    red_res_d   = red_res_q;
    red_val_d   = red_val_q;
    ir_val_d    = ir_val_q;
    valid_d     = 1'b0;
    frame_end_c = 1'b0;
    start_c     = 1'b0;
`ifdef LED_SCHED_DARK_PHASE_EN
    ir_res_d    = ir_res_q;
    dark_val_d  = dark_val_q;
`endif

    if (state_q != ST_IDLE) cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: start_c = en;
      ST_RED: begin
        if (last_c) begin
          red_res_d = avg_c;
          state_d   = ST_IR;
        end
      end
      ST_IR: begin
        if (last_c) begin
`ifdef LED_SCHED_DARK_PHASE_EN
          ir_res_d    = avg_c;
          state_d     = ST_DARK;
`else
          frame_end_c = 1'b1;
          red_val_d   = red_res_q;
          ir_val_d    = avg_c;
`endif
        end
      end
`ifdef LED_SCHED_DARK_PHASE_EN
      ST_DARK: begin
        if (last_c) begin
          frame_end_c = 1'b1;
          red_val_d   = sat_sub(red_res_q, avg_c);
          ir_val_d    = sat_sub(ir_res_q, avg_c);
          dark_val_d  = avg_c;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // en only matters on the last cycle of a frame (or while idle)
    if (frame_end_c) begin
      valid_d = 1'b1;
      if (en) start_c = 1'b1;
      else    state_d = ST_IDLE;
    end

    if (start_c) begin
      state_d       = ST_RED;
      cnt_d         = '0;
      cfg_d.red_pga = RED_PGA;
      cfg_d.red_dc  = RED_DC_Comp;
      cfg_d.ir_pga  = IR_PGA;
      cfg_d.ir_dc   = IR_DC_Comp;
    end

    // Drive outputs for the phase being entered so they switch on its cycle 0
    led_red_d = 1'b0;
    led_ir_d  = 1'b0;
    pga_d     = '0;
    dc_d      = '0;
    case (state_d)
      ST_RED: begin
        led_red_d = 1'b1;
        pga_d     = cfg_d.red_pga;
        dc_d      = cfg_d.red_dc;
      end
      ST_IR: begin
        led_ir_d = 1'b1;
        pga_d    = cfg_d.ir_pga;
        dc_d     = cfg_d.ir_dc;
      end
      ST_DARK: begin
        pga_d = cfg_d.ir_pga;
        dc_d  = cfg_d.ir_dc;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      red_res_q  <= '0;
      led_red_q  <= 1'b0;
      led_ir_q   <= 1'b0;
      pga_q      <= '0;
      dc_q       <= '0;
      red_val_q  <= '0;
      ir_val_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LED_SCHED_DARK_PHASE_EN
      ir_res_q   <= '0;
      dark_val_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      red_res_q  <= red_res_d;
      led_red_q  <= led_red_d;
      led_ir_q   <= led_ir_d;
      pga_q      <= pga_d;
      dc_q       <= dc_d;
      red_val_q  <= red_val_d;
      ir_val_q   <= ir_val_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef LED_SCHED_DARK_PHASE_EN
      ir_res_q   <= ir_res_d;
      dark_val_q <= dark_val_d;
`endif
    end
  end

  assign LED_RED       = led_red_q;
  assign LED_IR        = led_ir_q;
  assign PGA_Gain      = pga_q;
  assign DC_Comp       = dc_q;
  assign RED_ADC_Value = red_val_q;
  assign IR_ADC_Value  = ir_val_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
`ifdef LED_SCHED_DARK_PHASE_EN
  assign DARK_ADC_Value = dark_val_q;
`endif

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler: per-cycle output checks plus a
// scoreboard of expected averaged samples per frame.
module tb_led_phase_scheduler;
  import led_sched_pkg::*;

  localparam int unsigned PH = PHASE_CYCLES_DEF;
  localparam int unsigned ST = SETTLE_CYCLES_DEF;
  localparam int unsigned NW = PH - ST;

  logic       CLK = 1'b0;
  logic       rst_n, en;
  logic [3:0] RED_PGA, IR_PGA;
  logic [6:0] RED_DC_Comp, IR_DC_Comp;
  logic [7:0] ADC;
  logic       LED_RED, LED_IR;
  logic [3:0] PGA_Gain;
  logic [6:0] DC_Comp;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;
  logic       sample_valid, busy;
`ifdef LED_SCHED_DARK_PHASE_EN
  logic [7:0] DARK_ADC_Value;
`endif

  typedef struct {
    logic [7:0] red;
    logic [7:0] ir;
    logic [7:0] dark;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] m_rp, m_ip;
  logic [6:0] m_rd, m_id;
  logic [7:0] last_red = '0;
  logic [7:0] last_ir  = '0;
  bit         b2b = 1'b0;
  bit         mid_pga_req = 1'b0;
  logic [3:0] mid_pga = '0;
  int         en_lo_ph = -1, en_lo_c = -1, en_hi_ph = -1, en_hi_c = -1;

  led_phase_scheduler dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .en             (en),
    .RED_PGA        (RED_PGA),
    .RED_DC_Comp    (RED_DC_Comp),
    .IR_PGA         (IR_PGA),
    .IR_DC_Comp     (IR_DC_Comp),
    .ADC            (ADC),
    .LED_RED        (LED_RED),
    .LED_IR         (LED_IR),
    .PGA_Gain       (PGA_Gain),
    .DC_Comp        (DC_Comp),
    .RED_ADC_Value  (RED_ADC_Value),
    .IR_ADC_Value   (IR_ADC_Value),
`ifdef LED_SCHED_DARK_PHASE_EN
    .DARK_ADC_Value (DARK_ADC_Value),
`endif
    .sample_valid   (sample_valid),
    .busy           (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pack_obs();
    return {1'b0, LED_RED, LED_IR, PGA_Gain, DC_Comp, sample_valid, busy, RED_ADC_Value, IR_ADC_Value};
  endfunction

  function automatic logic [31:0] pack_exp(input logic lr, input logic li, input logic [3:0] p,
                                           input logic [6:0] d, input logic v, input logic b);
    return {1'b0, lr, li, p, d, v, b, last_red, last_ir};
  endfunction

  // One phase: settle cycles carry settle_v, window carries base + inc*k
  task automatic drive_phase(input int ph, input logic [7:0] settle_v, input logic [7:0] base,
                             input int inc, output logic [7:0] avg);
    int unsigned sum;
    logic [7:0]  v;
    sum = 0;
    for (int c = 0; c < int'(PH); c++) begin
      case (ph)
        0:       chk($sformatf("red_c%0d", c), pack_obs(), pack_exp(1'b1, 1'b0, m_rp, m_rd, (c == 0) && b2b, 1'b1));
        1:       chk($sformatf("ir_c%0d", c), pack_obs(), pack_exp(1'b0, 1'b1, m_ip, m_id, 1'b0, 1'b1));
        default: chk($sformatf("dark_c%0d", c), pack_obs(), pack_exp(1'b0, 1'b0, m_ip, m_id, 1'b0, 1'b1));
      endcase
      v = (c < int'(ST)) ? settle_v : 8'(int'(base) + inc * (c - int'(ST)));
      ADC = v;
      if (c >= int'(ST)) sum = sum + 32'(v);
      if (ph == 0 && c == 5 && mid_pga_req) begin
        RED_PGA = mid_pga;
        mid_pga_req = 1'b0;
      end
      if (ph == en_lo_ph && c == en_lo_c) en = 1'b0;
      if (ph == en_hi_ph && c == en_hi_c) en = 1'b1;
      tick();
    end
    avg = 8'(sum / NW);
  endtask

  // Called on RED cycle 0; returns on the cycle after the frame's last edge
  task automatic run_frame(input logic [7:0] rs, input logic [7:0] rb, input int ri,
                           input logic [7:0] is_, input logic [7:0] ib, input int ii,
                           input logic [7:0] dv);
    exp_t       e, got;
    logic [7:0] ra, ia;
`ifdef LED_SCHED_DARK_PHASE_EN
    logic [7:0] da;
`endif
    m_rp = RED_PGA;
    m_rd = RED_DC_Comp;
    m_ip = IR_PGA;
    m_id = IR_DC_Comp;
    drive_phase(0, rs, rb, ri, ra);
    b2b = 1'b0;
    drive_phase(1, is_, ib, ii, ia);
`ifdef LED_SCHED_DARK_PHASE_EN
    drive_phase(2, dv, dv, 0, da);
    e.red  = (ra > da) ? 8'(ra - da) : 8'd0;
    e.ir   = (ia > da) ? 8'(ia - da) : 8'd0;
    e.dark = da;
`else
    e.red  = ra;
    e.ir   = ia;
    e.dark = dv;
`endif
    sb.push_back(e);
    chk("sv_strobe", 32'(sample_valid), 32'd1);
    if (sample_valid === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      chk("sv_red", 32'(RED_ADC_Value), 32'(got.red));
      chk("sv_ir", 32'(IR_ADC_Value), 32'(got.ir));
`ifdef LED_SCHED_DARK_PHASE_EN
      chk("sv_dark", 32'(DARK_ADC_Value), 32'(got.dark));
`endif
    end
    last_red = e.red;
    last_ir  = e.ir;
    b2b      = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("idle_%0d", i), pack_obs(), pack_exp(1'b0, 1'b0, 4'd0, 7'd0, (i == 0) && b2b, 1'b0));
      b2b = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    RED_PGA = '0;
    RED_DC_Comp = '0;
    IR_PGA = '0;
    IR_DC_Comp = '0;
    ADC = '0;
    #12;
    chk("rst_outputs", pack_obs(), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    idle_cycles(3);

    // Constant ADC, back-to-back frames
    RED_PGA = 4'd5;
    RED_DC_Comp = 7'd20;
    IR_PGA = 4'd3;
    IR_DC_Comp = 7'd40;
    en = 1'b1;
    tick();
    run_frame(8'd100, 8'd100, 0, 8'd100, 8'd100, 0, 8'd100);
    run_frame(8'd100, 8'd100, 0, 8'd100, 8'd100, 0, 8'd100);
    // Settling samples excluded
    run_frame(8'd200, 8'd40, 0, 8'd60, 8'd60, 0, 8'd10);
    // Ramp 0..7 and full-scale window
    run_frame(8'd255, 8'd0, 1, 8'd255, 8'd255, 0, 8'd0);
    // Mid-frame PGA change takes effect next frame
    mid_pga = 4'd9;
    mid_pga_req = 1'b1;
    run_frame(8'd10, 8'd10, 0, 8'd20, 8'd20, 0, 8'd5);
    en = 1'b0;
    run_frame(8'd30, 8'd30, 0, 8'd40, 8'd40, 0, 8'd0);
    idle_cycles(2);

    // en glitch inside a frame is ignored, then en drop at IR cycle 3
    en = 1'b1;
    tick();
    en_lo_ph = 0;
    en_lo_c  = 3;
    en_hi_ph = 0;
    en_hi_c  = 6;
    run_frame(8'd150, 8'd150, 0, 8'd90, 8'd90, 0, 8'd100);
    en_lo_ph = 1;
    en_lo_c  = 3;
    en_hi_ph = -1;
    run_frame(8'd50, 8'd50, 2, 8'd70, 8'd60, 1, 8'd80);
    en_lo_ph = -1;
    idle_cycles(3);

    // Asynchronous reset in the middle of a RED phase
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ADC = 8'd77;
      tick();
    end
    rst_n = 1'b0;
    #1;
    last_red = '0;
    last_ir  = '0;
    b2b      = 1'b0;
    chk("rst_mid", pack_obs(), 32'd0);
    en = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    idle_cycles(2);

    // Recovery frame after reset
    en = 1'b1;
    tick();
    en = 1'b0;
    run_frame(8'd0, 8'd8, 0, 8'd1, 8'd1, 0, 8'd0);
    idle_cycles(2);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
